// File: rtl/mem_stage.sv
// Memory stage: latches one EXE->MEM instruction, runs a req/ack data-memory access, presents MEM_WB_BUS.
// Optional MEM_UNALIGNED_EXC_EN: misaligned half/word accesses raise AdEL/AdES instead of being masked.
//
// state     | meaning
// ST_EMPTY  | no instruction held
// ST_ACCESS | request outstanding, waiting for i_dmem_ack or timeout
// ST_HOLD   | result presented to writeback
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [109:0] i_exe_mem_bus,
    input  logic         i_exe_valid,
    output logic         o_mem_ready,
    output logic [67:0]  o_mem_wb_bus,
    output logic         o_wb_valid,
    input  logic         i_wb_ready,
    output logic         o_dmem_req,
    output logic         o_dmem_we,
    output logic [3:0]   o_dmem_be,
    output logic [31:0]  o_dmem_addr,
    output logic [31:0]  o_dmem_wdata,
    input  logic         i_dmem_ack,
    input  logic [31:0]  i_dmem_rdata,
    output logic         o_bus_err,
    output logic         o_exc,
    output logic [4:0]   o_exc_code,
    output logic [31:0]  o_badvaddr,
    output logic [31:0]  o_epc
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_EMPTY, ST_ACCESS, ST_HOLD} state_t;

    state_t           r_state;
    logic             r_req;
    logic [31:0]      r_addr;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [1:0]       r_size;
    logic             r_sign;
    logic             r_wb_en;
    logic [4:0]       r_wb_reg;
    logic [31:0]      r_wb_data;
    logic [29:0]      r_pc;
    logic             r_bus_err;
    logic             r_exc;
    logic [4:0]       r_exc_code;
    logic [31:0]      r_badvaddr;
    logic [CNT_W-1:0] r_cnt;

    logic [15:0] w_through;
    logic [31:0] w_alu;
    logic [31:0] w_out;
    logic [29:0] w_pc;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_is_mem;
    logic        w_byte;
    logic        w_half;
    logic        w_word;
    logic        w_misalign;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_accept;
    logic [7:0]  w_ld_b;
    logic [15:0] w_ld_h;
    logic [31:0] w_ld;
    logic        w_unused;

    assign w_through = i_exe_mem_bus[109:94];
    assign w_alu     = i_exe_mem_bus[93:62];
    assign w_out     = i_exe_mem_bus[61:30];
    assign w_pc      = i_exe_mem_bus[29:0];
    assign w_unused  = ^w_through[4:0];

    assign w_mem_rd = w_through[15];
    assign w_mem_wr = w_through[14];
    assign w_is_mem = w_mem_rd | w_mem_wr;
    assign w_byte   = (w_through[13:12] == 2'b00);
    assign w_half   = (w_through[13:12] == 2'b01);
    assign w_word   = w_through[13];

`ifdef MEM_UNALIGNED_EXC_EN
    assign w_misalign = w_is_mem & ((w_half & w_alu[0]) | (w_word & (w_alu[1:0] != 2'b00)));
    assign w_addr     = w_alu;
`else
    assign w_misalign = 1'b0;
    assign w_addr     = {w_alu[31:2], w_word ? 2'b00 : {w_alu[1], w_alu[0] & w_byte}};
`endif

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_out;
        if (w_byte) begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {4{w_out[7:0]}};
        end else if (w_half) begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{w_out[15:0]}};
        end
    end

    // Load lane extraction works on the latched (aligned) address, so it is stable through ACCESS.
    assign w_ld_b = i_dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_ld_h = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    always_comb begin
        w_ld = i_dmem_rdata;
        case (r_size)
            2'b00:   w_ld = {{24{r_sign & w_ld_b[7]}}, w_ld_b};
            2'b01:   w_ld = {{16{r_sign & w_ld_h[15]}}, w_ld_h};
            default: w_ld = i_dmem_rdata;
        endcase
    end

    assign o_mem_ready = (r_state == ST_EMPTY) | ((r_state == ST_HOLD) & i_wb_ready);
    assign w_accept    = i_exe_valid & o_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_EMPTY;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_sign     <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_data  <= '0;
            r_pc       <= '0;
            r_bus_err  <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_code <= '0;
            r_badvaddr <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_ACCESS: begin
                    if (i_dmem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_HOLD;
                        if (!r_we) r_wb_data <= w_ld;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TC_LAST)) begin
                        r_req     <= 1'b0;
                        r_state   <= ST_HOLD;
                        r_bus_err <= 1'b1;
                        r_wb_en   <= 1'b0;
                        r_wb_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_wb_ready) r_state <= ST_EMPTY;
                end
                default: ;
            endcase

            // A new instruction overrides the HOLD->EMPTY drain, giving bubble-free handover.
            if (w_accept) begin
                r_addr     <= w_addr;
                r_we       <= w_mem_wr;
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_size     <= w_through[13:12];
                r_sign     <= w_through[11];
                r_wb_en    <= w_through[10] & ~w_mem_wr & ~w_misalign;
                r_wb_reg   <= w_through[9:5];
                r_wb_data  <= w_out;
                r_pc       <= w_pc;
                r_bus_err  <= 1'b0;
                r_exc      <= w_misalign;
                r_exc_code <= w_misalign ? (w_mem_wr ? 5'd5 : 5'd4) : 5'd0;
                r_badvaddr <= w_misalign ? w_alu : 32'd0;
                r_cnt      <= '0;
                if (w_is_mem & ~w_misalign) begin
                    r_state <= ST_ACCESS;
                    r_req   <= 1'b1;
                end else begin
                    r_state <= ST_HOLD;
                    r_req   <= 1'b0;
                end
            end
        end
    end

    assign o_wb_valid   = (r_state == ST_HOLD);
    assign o_mem_wb_bus = {r_wb_en, r_wb_reg, r_wb_data, r_pc};
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_be    = r_be;
    assign o_dmem_addr  = {r_addr[31:2], 2'b00};
    assign o_dmem_wdata = r_wdata;
    assign o_bus_err    = r_bus_err;
    assign o_exc        = r_exc;
    assign o_exc_code   = r_exc_code;
    assign o_badvaddr   = r_badvaddr;
    assign o_epc        = {r_pc, 2'b00};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model checked every cycle, directed cases with literal values, then random traffic.
module tb_mem_stage;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [109:0] exe_bus;
    logic         exe_valid;
    logic         mem_ready;
    logic [67:0]  wb_bus;
    logic         wb_valid;
    logic         wb_ready;
    logic         dmem_req;
    logic         dmem_we;
    logic [3:0]   dmem_be;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;
    logic         bus_err;
    logic         exc;
    logic [4:0]   exc_code;
    logic [31:0]  badvaddr;
    logic [31:0]  epc;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_exe_mem_bus(exe_bus), .i_exe_valid(exe_valid),
        .o_mem_ready(mem_ready), .o_mem_wb_bus(wb_bus), .o_wb_valid(wb_valid),
        .i_wb_ready(wb_ready), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_dmem_be(dmem_be), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata), .o_bus_err(bus_err),
        .o_exc(exc), .o_exc_code(exc_code), .o_badvaddr(badvaddr), .o_epc(epc)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one held instruction, whether its memory access is still pending, and its result.
    bit          m_have, m_wait;
    int          m_cnt, e_nb, e_lane;
    bit          e_we, e_sign, e_wb_en, e_bus_err, e_exc;
    logic [31:0] e_addr, e_wdata, e_wb_data, e_bad;
    logic [3:0]  e_be;
    logic [4:0]  e_wb_reg, e_code;
    logic [29:0] e_pc;

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] th(bit rd, bit wr, logic [1:0] sz, bit sg, bit we, logic [4:0] rg);
        return {rd, wr, sz, sg, we, rg, 5'b00000};
    endfunction

    function automatic logic [31:0] ext(logic [31:0] rd, int nb, int lane, bit sg);
        logic [63:0] v, mask;
        v = 64'(rd) >> (8 * lane);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = v & mask;
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic m_load(input logic [109:0] b);
        logic [15:0] t;
        logic [31:0] alu, od, a;
        bit mis;
        t = b[109:94]; alu = b[93:62]; od = b[61:30];
        e_nb = (t[13:12] == 2'b00) ? 1 : (t[13:12] == 2'b01) ? 2 : 4;
        mis = 0;
`ifdef MEM_UNALIGNED_EXC_EN
        mis = (t[15] || t[14]) && (alu % e_nb != 0);
`endif
        a = alu - (alu % e_nb);
        e_addr = a & ~32'd3;
        e_lane = int'(a % 4);
        e_be = 4'(((1 << e_nb) - 1) << e_lane);
        for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = od[8*(i % e_nb) +: 8];
        e_we = t[14];
        e_sign = t[11];
        e_wb_en = t[10] && !t[14] && !mis;
        e_wb_reg = t[9:5];
        e_wb_data = od;
        e_pc = b[29:0];
        e_bus_err = 0;
        e_exc = mis;
        e_code = mis ? (t[14] ? 5'd5 : 5'd4) : 5'd0;
        e_bad = mis ? alu : 32'd0;
        m_have = 1;
        m_wait = (t[15] || t[14]) && !mis;
        m_cnt = 0;
    endtask

    function automatic bit m_ready();
        return !m_have || (!m_wait && wb_ready);
    endfunction

    task automatic m_check();
        chk("mem_ready", mem_ready, m_ready());
        chk("dmem_req", dmem_req, m_have && m_wait);
        chk("wb_valid", wb_valid, m_have && !m_wait);
        if (m_have && m_wait) begin
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_we_be", {dmem_we, dmem_be}, {e_we, e_be});
            chk("dmem_wdata", dmem_wdata, e_wdata);
        end
        if (m_have && !m_wait) begin
            chk("mem_wb_bus", wb_bus, {e_wb_en, e_wb_reg, e_wb_data, e_pc});
            chk("err_exc", {bus_err, exc, exc_code}, {e_bus_err, e_exc, e_code});
            chk("badvaddr", badvaddr, e_bad);
            chk("epc", epc, {e_pc, 2'b00});
        end
    endtask

    task automatic m_step();
        bit acc;
        if (rst) begin
            m_have = 0;
            m_wait = 0;
        end else begin
            acc = exe_valid && m_ready();
            if (m_have && m_wait) begin
                if (dmem_ack) begin
                    m_wait = 0;
                    if (!e_we) e_wb_data = ext(dmem_rdata, e_nb, e_lane, e_sign);
                end else begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_wait = 0;
                        e_bus_err = 1;
                        e_wb_en = 0;
                        e_wb_data = 0;
                    end
                end
            end else if (m_have && wb_ready) begin
                m_have = 0;
            end
            if (acc) m_load(exe_bus);
        end
    endtask

    task automatic drv(input bit r, input bit ev, input logic [109:0] b, input bit wr,
                       input bit ack, input logic [31:0] rd);
        @(negedge clk);
        rst = r; exe_valid = ev; exe_bus = b; wb_ready = wr; dmem_ack = ack; dmem_rdata = rd;
        #1;
        m_check();
    endtask

    task automatic adv();
        m_step();
        @(posedge clk);
    endtask

    task automatic dir_mem(input string nm, input logic [15:0] t, input logic [31:0] alu,
                           input logic [31:0] od, input logic [31:0] rd, input logic [31:0] x_addr,
                           input logic [3:0] x_be, input logic [31:0] x_wdata, input bit x_we,
                           input bit x_wben, input logic [31:0] x_data);
        drv(0, 1, {t, alu, od, 30'h0000_1234}, 1, 0, 0);
        chk({nm, "_accept_ready"}, mem_ready, 1'b1);
        adv();
        drv(0, 0, '0, 1, 1, rd);
        chk({nm, "_req"}, dmem_req, 1'b1);
        chk({nm, "_addr"}, dmem_addr, x_addr);
        chk({nm, "_be"}, dmem_be, x_be);
        chk({nm, "_we"}, dmem_we, x_we);
        if (x_we) chk({nm, "_wdata"}, dmem_wdata, x_wdata);
        adv();
        drv(0, 0, '0, 1, 0, 0);
        chk({nm, "_wb_valid"}, wb_valid, 1'b1);
        chk({nm, "_wb_en"}, wb_bus[67], x_wben);
        if (!x_we) chk({nm, "_wb_data"}, wb_bus[61:30], x_data);
        adv();
    endtask

    function automatic logic [109:0] rand_bus();
        int op;
        logic [15:0] t;
        op = $urandom_range(0, 2);
        t = {op == 1, op == 2, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom)};
        return {t, 32'($urandom), 32'($urandom), 30'($urandom)};
    endfunction

    initial begin
        logic [31:0] od_last;
        rst = 1; exe_valid = 0; exe_bus = '0; wb_ready = 0; dmem_ack = 0; dmem_rdata = '0;
        m_have = 0; m_wait = 0; m_cnt = 0;
        repeat (2) @(posedge clk);

        drv(0, 0, '0, 0, 0, 0);
        chk("rst_ready", mem_ready, 1'b1);
        chk("rst_flags", {dmem_req, wb_valid, bus_err, exc, exc_code}, 9'd0);
        chk("rst_wb_bus", wb_bus, 68'd0);
        chk("rst_addr_epc", {dmem_addr, epc}, 64'd0);
        adv();

        dir_mem("lw", th(1, 0, 2'b10, 0, 1, 5'd3), 32'h100, 32'h55, 32'hDEADBEEF,
                32'h100, 4'b1111, 32'h0, 0, 1, 32'hDEADBEEF);
        dir_mem("lbs", th(1, 0, 2'b00, 1, 1, 5'd4), 32'h103, 32'h0, 32'h80FFFFFF,
                32'h100, 4'b1000, 32'h0, 0, 1, 32'hFFFFFF80);
        dir_mem("lbu", th(1, 0, 2'b00, 0, 1, 5'd4), 32'h103, 32'h0, 32'h80FFFFFF,
                32'h100, 4'b1000, 32'h0, 0, 1, 32'h00000080);
        dir_mem("sh", th(0, 1, 2'b01, 0, 1, 5'd6), 32'h202, 32'h1234ABCD, 32'h0,
                32'h200, 4'b1100, 32'hABCDABCD, 1, 0, 32'h0);

        od_last = '0;
        for (int i = 0; i < 5; i++) begin
            od_last = 32'h1000 + 32'(i);
            drv(0, 1, {th(0, 0, 2'b10, 0, 1, 5'(i)), 32'h0, od_last, 30'(i)}, 1, 0, 0);
            chk("alu_b2b_ready", mem_ready, 1'b1);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, {th(0, 0, 2'b10, 0, 1, 5'd9), 32'h0, 32'h9999, 30'd9}, 0, 0, 0);
            chk("stall_ready", mem_ready, 1'b0);
            chk("stall_bus", wb_bus, {1'b1, 5'd4, od_last, 30'd4});
            adv();
        end
        drv(0, 1, {th(0, 0, 2'b10, 0, 1, 5'd9), 32'h0, 32'h9999, 30'd9}, 1, 0, 0);
        adv();
        drv(0, 0, '0, 1, 0, 0);
        chk("no_bubble_bus", wb_bus, {1'b1, 5'd9, 32'h9999, 30'd9});
        adv();

        drv(0, 1, {th(1, 0, 2'b10, 0, 1, 5'd7), 32'h300, 32'h77, 30'd3}, 0, 0, 0);
        adv();
        for (int i = 0; i < TO; i++) begin
            drv(0, 0, '0, 0, 0, 0);
            chk("to_req_high", dmem_req, 1'b1);
            adv();
        end
        drv(0, 0, '0, 0, 1, 32'hFFFF_FFFF);
        chk("to_req_dropped", dmem_req, 1'b0);
        chk("to_result", {wb_valid, bus_err, wb_bus[67], wb_bus[61:30]}, {3'b110, 32'h0});
        adv();
        drv(0, 0, '0, 1, 1, 32'h1234_5678);
        chk("to_stray_ack", {bus_err, wb_bus[61:30]}, {1'b1, 32'h0});
        adv();

        drv(0, 1, {th(1, 0, 2'b10, 0, 1, 5'd8), 32'h102, 32'h0, 30'd5}, 1, 0, 0);
        adv();
        drv(0, 0, '0, 1, 0, 0);
`ifdef MEM_UNALIGNED_EXC_EN
        chk("ade_no_req", dmem_req, 1'b0);
        chk("ade_exc", {wb_valid, exc, exc_code, wb_bus[67]}, {1'b1, 1'b1, 5'd4, 1'b0});
        chk("ade_badvaddr", badvaddr, 32'h102);
`else
        chk("mask_req", dmem_req, 1'b1);
        chk("mask_addr", dmem_addr, 32'h100);
`endif
        adv();
        repeat (2) begin
            drv(0, 0, '0, 1, 1, 32'h0);
            adv();
        end

        drv(0, 1, {th(1, 0, 2'b10, 0, 1, 5'd1), 32'h400, 32'h0, 30'd6}, 1, 0, 0);
        adv();
        drv(0, 0, '0, 1, 0, 0);
        chk("rst_mid_req", dmem_req, 1'b1);
        adv();
        drv(1, 0, '0, 1, 0, 0);
        adv();
        drv(0, 0, '0, 1, 1, 32'hABCD_0000);
        chk("rst_mid_after", {dmem_req, wb_valid, mem_ready}, 3'b001);
        adv();

        for (int c = 0; c < 3000; c++) begin
            drv($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, rand_bus(),
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 32'($urandom));
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EXE→MEM pipeline interface: accepts the 110-bit EXE_MEM_BUS, performs the data-memory access, and presents MEM_WB_BUS to writeback.
- Produces the next_valid input of the execute stage as mem_ready.
- Buffers one instruction and drives a req/ack data-memory port.
- Handles byte/half/word lanes, sign extension and access timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ACCESS waiting for dmem_ack; 0 disables the timeout.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- EXE_MEM_BUS  in  110  {through[15:0], alu_data[31:0], out_data[31:0], pc[29:0]}.
- exe_valid  in  1  EXE_MEM_BUS holds a finished instruction.
- mem_ready  out  1  mem_stage can accept this cycle; drives the EXE stage next_valid.
- MEM_WB_BUS  out  68  {wb_en, wb_reg[4:0], wb_data[31:0], pc[29:0]}.
- wb_valid  out  1  MEM_WB_BUS valid.
- wb_ready  in  1  writeback consumes MEM_WB_BUS.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  access complete; dmem_rdata valid on the same cycle.
- dmem_rdata  in  32  load data.
- bus_err  out  1  access timed out; valid while wb_valid.
- exc  out  1  address exception; valid while wb_valid.
- exc_code  out  5  4 = AdEL, 5 = AdES.
- badvaddr  out  32  faulting address.
- epc  out  32  {pc, 2'b00} of the held instruction.

Behaviour:
- through field map:
  - [15] mem_read, [14] mem_write.
  - [13:12] size: 00 byte, 01 half, 10 word, 11 treated as word.
  - [11] sign-extend load.
  - [10] wb_en, [9:5] wb_reg.
  - [4:0] reserved, ignored.
- Address = alu_data. Store data = out_data.
- States:
  - EMPTY: no instruction held.
  - ACCESS: waiting for dmem_ack.
  - HOLD: result presented to writeback.
- mem_ready = (state==EMPTY) | (state==HOLD & wb_ready). Combinational in wb_ready.
- Accept = exe_valid & mem_ready. On accept the bus is latched and the next state is chosen as follows:
  - mem_read|mem_write, no exception → ACCESS. dmem_req rises the cycle after accept (registered).
  - Otherwise → HOLD, with wb_data = out_data. Exception cases take this path: exc set, no request issued, wb_en = 0.
- ACCESS:
  - dmem_req = 1.
  - addr, we, be, wdata held stable until the ack cycle.
  - On dmem_ack: capture the extracted load → HOLD. dmem_req = 0 from the next cycle.
  - Minimum load latency accept→wb_valid is 2 cycles with a zero-wait ack.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{out_data[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{out_data[15:0]}}.
  - word: be = 1111; wdata = out_data.
- Loads:
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - Result is zero- or sign-extended per bit [11].
- Stores and mem_write: wb_en forced to 0.
- HOLD:
  - wb_valid = 1.
  - On wb_ready with a simultaneous accept: load the new instruction. No bubble.
  - On wb_ready without accept → EMPTY.
- Timeout:
  - Cycle counter runs in ACCESS, cleared on entry.
  - Reaching TIMEOUT_CYCLES without ack: drop dmem_req, go to HOLD with bus_err = 1, wb_en = 0, wb_data = 0.
- dmem_ack outside ACCESS is ignored. This covers a late ack after reset or after a timeout.
- Reset, including mid-ACCESS:
  - state = EMPTY.
  - dmem_req, wb_valid, bus_err, exc = 0 from the next cycle.
  - All registered outputs and the counter = 0.
  - The outstanding access is abandoned.
- exc, exc_code, badvaddr, bus_err, epc are held constant for the whole HOLD residency.

Optional Feature:
- MEM_UNALIGNED_EXC_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no request.
  - The instruction goes straight to HOLD with exc = 1, exc_code = 4 (load) or 5 (store), badvaddr = alu_data, wb_en = 0.
- Undefined:
  - Low address bits are masked to size alignment (half clears bit0, word clears bits1:0).
  - exc, exc_code, badvaddr are tied to 0.

Test Plan:
- Load word, alu_data=0x100, sign=0; ack 1 cycle after req, rdata=0xDEADBEEF → wb_valid 2 cycles after accept, wb_data=0xDEADBEEF, wb_en=1.
- Load byte signed, addr=0x103, rdata=0x80FFFFFF → dmem_addr=0x100, wb_data=0xFFFFFF80. Unsigned variant → 0x00000080.
- Store half, addr=0x202, out_data=0x1234ABCD → dmem_we=1, be=1100, wdata=0xABCDABCD, wb_en=0.
- Back-to-back ALU-only ops, wb_ready held 1 → mem_ready stays 1, one result per cycle. Drop wb_ready for 3 cycles → MEM_WB_BUS stable and mem_ready=0 for those cycles.
- TIMEOUT_CYCLES=4, ack never arrives → req drops after 4 ACCESS cycles, bus_err=1, wb_en=0. A later stray ack has no effect.
- Word load at 0x102 with MEM_UNALIGNED_EXC_EN → no dmem_req, exc=1, exc_code=4, badvaddr=0x102. Assert rst during ACCESS → dmem_req=0 and wb_valid=0 the next cycle.
